disp_scan_ctrl: RTL



---
 rtl/disp_scan_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display: digit select, dead time, PWM.
// Define DISP_LAMP_TEST_EN to add the lamp_test input that forces every anode on.
module disp_scan_ctrl #(
  parameter int TICK_DIV   = 12500,
  parameter int DEAD_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  input  logic [3:0] brightness,
`ifdef DISP_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [3:0] sel,
  output logic [3:0] an_n,
  output logic       frame_start
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [4:0]    DEAD5    = 5'(DEAD_TICKS);

  typedef enum logic [1:0] {IDLE, DEAD, ON, OFF} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    phase_q, phase_d;
  logic [3:0]    mask_q,  mask_d;
  logic [3:0]    sel_q,   sel_d;
  logic [3:0]    an_n_q,  an_n_d;
  logic          fs_q,    fs_d;
  logic [3:0]    an_fsm;

  // 5-bit compares so DEAD_TICKS + brightness can exceed 15 and clip the ON window.
  function automatic state_t classify(input logic [3:0] ph, input logic [3:0] br);
    logic [4:0] ph5;
    logic [4:0] lim;
    ph5 = {1'b0, ph};
    lim = DEAD5 + {1'b0, br};
    if ((ph5 + 5'd1) <= DEAD5)  return DEAD;
    else if (ph5 < lim)         return ON;
    else                        return OFF;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

  // Nearest set bit above the current digit, wrapping; the current digit itself is last resort.
  function automatic logic [3:0] next_sel(input logic [3:0] cur, input logic [3:0] m);
    logic [1:0] c;
    logic [1:0] j;
    logic [3:0] res;
    c   = idx_of(cur);
    res = cur;
    for (int i = 4; i >= 1; i--) begin
      j = c + 2'(i);
      if (m[j]) res = 4'b0001 << j;
    end
    return res;
  endfunction

  function automatic logic [3:0] low_bit(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    fs_d    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      phase_d = 4'd0;
    end else if (state_q == IDLE) begin
      state_d = classify(4'd0, brightness);
      mask_d  = digit_mask;
      presc_d = '0;
      phase_d = 4'd0;
    end else if (presc_q == PRESC_TC) begin
      presc_d = '0;
      phase_d = phase_q + 4'd1;
      state_d = classify(phase_d, brightness);
      if (phase_q == 4'd15) begin
        mask_d = digit_mask;
        if (digit_mask != 4'd0) begin
          sel_d = next_sel(sel_q, digit_mask);
          fs_d  = (sel_d == low_bit(digit_mask));
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end

    an_fsm = ((state_d == ON) && (mask_d != 4'd0)) ? ~sel_d : 4'hF;
`ifdef DISP_LAMP_TEST_EN
    an_n_d = lamp_test ? 4'h0 : an_fsm;
`else
    an_n_d = an_fsm;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      phase_q <= 4'd0;
      mask_q  <= 4'd0;
      sel_q   <= 4'b0001;
      an_n_q  <= 4'hF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      an_n_q  <= an_n_d;
      fs_q    <= fs_d;
    end
  end

  assign sel         = sel_q;
  assign an_n        = an_n_q;
  assign frame_start = fs_q;

endmodule
